vx_rsp_tag_router: RTL and testbench

// - Sits directly downstream of a NUM_REQS:1 stream arbiter. Forwards each granted request
//   and records the arbiter select index (sel) of every accepted request in an in-order tag FIFO.
// - Steers the in-order response stream back to the requester that issued the matching request.
// - Lets N requesters share one in-order memory/unit port without carrying tags through it.

---
 rtl/vx_rsp_tag_router_pkg.sv | 14 +
 rtl/vx_rsp_tag_fifo.sv | 66 ++++++
 rtl/vx_rsp_tag_router.sv | 85 ++++++++
 tb/tb_vx_rsp_tag_router.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_rsp_tag_router_pkg.sv
// Width helpers shared by the response tag router and its tag FIFO.
package vx_rsp_tag_router_pkg;

  // Never returns zero, so that a lone requester still gets a 1-bit select.
  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold every value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vx_rsp_tag_fifo.sv
// In-order FIFO of arbiter select tags, with a registered occupancy count and full/empty flags.
module vx_rsp_tag_fifo
  import vx_rsp_tag_router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATAW = 1,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [DATAW-1:0] i_data,
  input  logic             i_pop,
  output logic [DATAW-1:0] o_head,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATAW-1:0] r_tags [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_pending;

  // Tag storage is deliberately left unreset; empty gates every read of it.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_tags[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_pending <= r_pending + CNT_W'(1);
        2'b01:   r_pending <= r_pending - CNT_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_head    = r_tags[r_rd_ptr[AW-1:0]];
  assign o_pending = r_pending;
  assign o_full    = (r_pending == CNT_W'(DEPTH));
  assign o_empty   = (r_pending == '0);

  a_no_overflow : assert property (@(posedge clk) disable iff (reset) i_push |-> !o_full);
  a_no_underflow : assert property (@(posedge clk) disable iff (reset) i_pop |-> !o_empty);
  // The wrap-bit pointer distance must always agree with the separately kept count.
  a_ptr_count : assert property (@(posedge clk) disable iff (reset)
    r_pending == CNT_W'(r_wr_ptr - r_rd_ptr));

endmodule

// File: rtl/vx_rsp_tag_router.sv
// Forwards arbitrated requests, remembers each one's select index, and steers in-order responses back.
module vx_rsp_tag_router
  import vx_rsp_tag_router_pkg::*;
#(
  parameter int NUM_REQS    = 2,
  parameter int REQ_DATAW   = 1,
  parameter int RSP_DATAW   = 1,
  parameter int MAX_PENDING = 4,
  parameter int TAG_W       = up_clog2(NUM_REQS),
  parameter int CNT_W       = cnt_width(MAX_PENDING)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid_in,
  input  logic [REQ_DATAW-1:0]          req_data_in,
  input  logic [TAG_W-1:0]              req_sel_in,
  output logic                          req_ready_in,
  output logic                          req_valid_out,
  output logic [REQ_DATAW-1:0]          req_data_out,
  input  logic                          req_ready_out,
  input  logic                          rsp_valid_in,
  input  logic [RSP_DATAW-1:0]          rsp_data_in,
  output logic                          rsp_ready_in,
  output logic [NUM_REQS-1:0]           rsp_valid_out,
  output logic [NUM_REQS*RSP_DATAW-1:0] rsp_data_out,
  input  logic [NUM_REQS-1:0]           rsp_ready_out,
  output logic [CNT_W-1:0]              pending,
  output logic                          full,
  output logic                          empty
);

  logic                w_full;
  logic                w_empty;
  logic [TAG_W-1:0]    w_head;
  logic [NUM_REQS-1:0] w_head_onehot;
  logic                w_head_in_range;
  logic                w_req_fire;
  logic                w_rsp_fire;

  vx_rsp_tag_fifo #(
    .DEPTH (MAX_PENDING),
    .DATAW (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_req_fire),
    .i_data    (req_sel_in),
    .i_pop     (w_rsp_fire),
    .o_head    (w_head),
    .o_pending (pending),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Gating on full alone (not on a same-cycle pop) keeps ready independent of the response side.
  assign req_valid_out = req_valid_in && !w_full;
  assign req_ready_in  = req_ready_out && !w_full;
  assign req_data_out  = req_data_in;
  assign w_req_fire    = req_valid_in && req_ready_in;

  // An out-of-range head tag decodes to all zeros, which starves both valid and ready.
  always_comb begin
    w_head_onehot = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_head_onehot[k] = (w_head == TAG_W'(k));
    end
  end

  assign w_head_in_range = |w_head_onehot;
  assign rsp_valid_out   = {NUM_REQS{rsp_valid_in && !w_empty}} & w_head_onehot;
  assign rsp_ready_in    = !w_empty && (|(w_head_onehot & rsp_ready_out));
  assign rsp_data_out    = {NUM_REQS{rsp_data_in}};
  assign w_rsp_fire      = rsp_valid_in && rsp_ready_in;

  assign full  = w_full;
  assign empty = w_empty;

  a_head_in_range : assert property (@(posedge clk) disable iff (reset)
    !w_empty |-> w_head_in_range);
  // A response stalling against an empty FIFO for more than one cycle is worth noticing.
  c_rsp_while_empty : cover property (@(posedge clk) disable iff (reset)
    rsp_valid_in && w_empty && $past(rsp_valid_in && w_empty));

endmodule

// File: tb/tb_vx_rsp_tag_router.sv
// Directed bench for vx_rsp_tag_router with four requesters and a four-deep tag FIFO.
module tb_vx_rsp_tag_router;

  localparam int NUM_REQS    = 4;
  localparam int REQ_DATAW   = 8;
  localparam int RSP_DATAW   = 8;
  localparam int MAX_PENDING = 4;
  localparam int TAG_W       = 2;
  localparam int CNT_W       = 3;

  logic                          clk;
  logic                          reset;
  logic                          req_valid_in;
  logic [REQ_DATAW-1:0]          req_data_in;
  logic [TAG_W-1:0]              req_sel_in;
  logic                          req_ready_in;
  logic                          req_valid_out;
  logic [REQ_DATAW-1:0]          req_data_out;
  logic                          req_ready_out;
  logic                          rsp_valid_in;
  logic [RSP_DATAW-1:0]          rsp_data_in;
  logic                          rsp_ready_in;
  logic [NUM_REQS-1:0]           rsp_valid_out;
  logic [NUM_REQS*RSP_DATAW-1:0] rsp_data_out;
  logic [NUM_REQS-1:0]           rsp_ready_out;
  logic [CNT_W-1:0]              pending;
  logic                          full;
  logic                          empty;

  int checks = 0;
  int errors = 0;

  vx_rsp_tag_router #(
    .NUM_REQS    (NUM_REQS),
    .REQ_DATAW   (REQ_DATAW),
    .RSP_DATAW   (RSP_DATAW),
    .MAX_PENDING (MAX_PENDING),
    .TAG_W       (TAG_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_sel_in    (req_sel_in),
    .req_ready_in  (req_ready_in),
    .req_valid_out (req_valid_out),
    .req_data_out  (req_data_out),
    .req_ready_out (req_ready_out),
    .rsp_valid_in  (rsp_valid_in),
    .rsp_data_in   (rsp_data_in),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_ready_out (rsp_ready_out),
    .pending       (pending),
    .full          (full),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change mid-cycle and are given 1 time unit to settle before any check.
  task automatic applyStimulus(input logic reqValid, input logic [TAG_W-1:0] sel,
                               input logic [REQ_DATAW-1:0] reqData, input logic reqReadyOut,
                               input logic rspValid, input logic [RSP_DATAW-1:0] rspData,
                               input logic [NUM_REQS-1:0] rspReadyOut);
    req_valid_in  = reqValid;
    req_sel_in    = sel;
    req_data_in   = reqData;
    req_ready_out = reqReadyOut;
    rsp_valid_in  = rspValid;
    rsp_data_in   = rspData;
    rsp_ready_out = rspReadyOut;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    req_valid_in  = 1'b0;
    req_sel_in    = '0;
    req_data_in   = '0;
    req_ready_out = 1'b0;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_ready_out = '0;
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_req_ready_in", 32'(req_ready_in), 32'd0);
    checkOutput("rst_rsp_ready_in", 32'(rsp_ready_in), 32'd0);
    checkOutput("rst_rsp_valid_out", 32'(rsp_valid_out), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] back-to-back pushes 0,1,0 then responses A,B,C");
    applyStimulus(1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 8'h00, 4'b1111);
    checkOutput("push0_req_valid_out", 32'(req_valid_out), 32'd1);
    checkOutput("push0_req_ready_in", 32'(req_ready_in), 32'd1);
    checkOutput("push0_req_data_out", 32'(req_data_out), 32'h11);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h22, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd0, 8'h33, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA0, 4'b1111);
    checkOutput("three_pending", 32'(pending), 32'd3);
    checkOutput("rspA_lane", 32'(rsp_valid_out), 32'b0001);
    checkOutput("rspA_ready", 32'(rsp_ready_in), 32'd1);
    checkOutput("rspA_data", rsp_data_out, 32'hA0A0A0A0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hB0, 4'b1111);
    checkOutput("rspB_pending", 32'(pending), 32'd2);
    checkOutput("rspB_lane", 32'(rsp_valid_out), 32'b0010);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hC0, 4'b1111);
    checkOutput("rspC_lane", 32'(rsp_valid_out), 32'b0001);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b1111);
    checkOutput("drain_empty", 32'(empty), 32'd1);

    $display("[TB] fill to capacity with request held");
    applyStimulus(1'b1, 2'd1, 8'h41, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h42, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd3, 8'h43, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd0, 8'h44, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h45, 1'b1, 1'b0, 8'h00, 4'b1111);
    checkOutput("fill_pending", 32'(pending), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_req_ready_in", 32'(req_ready_in), 32'd0);
    checkOutput("fill_req_valid_out", 32'(req_valid_out), 32'd0);
    applyStimulus(1'b1, 2'd2, 8'h45, 1'b1, 1'b1, 8'hD0, 4'b1111);
    checkOutput("full_pop_lane", 32'(rsp_valid_out), 32'b0010);
    checkOutput("full_pop_blocks_push", 32'(req_ready_in), 32'd0);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h45, 1'b1, 1'b0, 8'h00, 4'b1111);
    checkOutput("after_pop_pending", 32'(pending), 32'd3);
    checkOutput("after_pop_req_ready_in", 32'(req_ready_in), 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hE0, 4'b1011);
    checkOutput("refill_pending", 32'(pending), 32'd4);

    $display("[TB] head lane not ready stalls the response");
    checkOutput("stall_lane", 32'(rsp_valid_out), 32'b0100);
    checkOutput("stall_rsp_ready_in", 32'(rsp_ready_in), 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hE0, 4'b1111);
    checkOutput("stall_no_pop", 32'(pending), 32'd4);
    checkOutput("unstall_rsp_ready_in", 32'(rsp_ready_in), 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hE1, 4'b1111);
    checkOutput("unstall_pending", 32'(pending), 32'd3);
    checkOutput("lane3_head", 32'(rsp_valid_out), 32'b1000);
    tick();

    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b1, 2'd3, 8'h46, 1'b1, 1'b1, 8'hE2, 4'b1111);
    checkOutput("pushpop_lane", 32'(rsp_valid_out), 32'b0001);
    checkOutput("pushpop_req_ready_in", 32'(req_ready_in), 32'd1);
    checkOutput("pushpop_rsp_ready_in", 32'(rsp_ready_in), 32'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hE3, 4'b1111);
    checkOutput("pushpop_pending", 32'(pending), 32'd2);
    checkOutput("order_lane2", 32'(rsp_valid_out), 32'b0100);
    tick();
    checkOutput("order_lane3", 32'(rsp_valid_out), 32'b1000);
    tick();

    $display("[TB] response arriving while empty");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h5A, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty_rsp_ready_in", 32'(rsp_ready_in), 32'd0);
      checkOutput("empty_rsp_valid_out", 32'(rsp_valid_out), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 2'd1, 8'h47, 1'b1, 1'b1, 8'h5A, 4'b1111);
    checkOutput("no_bypass_lane", 32'(rsp_valid_out), 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h5A, 4'b1111);
    checkOutput("late_lane1", 32'(rsp_valid_out), 32'b0010);
    checkOutput("late_data", rsp_data_out, 32'h5A5A5A5A);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 4'b1111);
    checkOutput("late_empty", 32'(empty), 32'd1);

    $display("[TB] reset in the middle of a response");
    applyStimulus(1'b1, 2'd0, 8'h51, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h52, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h53, 1'b1, 1'b0, 8'h00, 4'b1111);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h77, 4'b1111);
    checkOutput("pre_reset_pending", 32'(pending), 32'd3);
    checkOutput("pre_reset_lane", 32'(rsp_valid_out), 32'b0001);
    reset = 1'b1;
    #1;
    checkOutput("midrst_pending", 32'(pending), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_full", 32'(full), 32'd0);
    checkOutput("midrst_rsp_valid_out", 32'(rsp_valid_out), 32'd0);
    checkOutput("midrst_rsp_ready_in", 32'(rsp_ready_in), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("postrst_rsp_ready_in", 32'(rsp_ready_in), 32'd0);
    tick();
    checkOutput("postrst_pending", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
